stair_detect: RTL and testbench

STAIR_DETECT -- requirements
Module: stair_detect

---
 rtl/stair_detect.sv | 88 ++++++++
 tb/tb_stair_detect.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stair_detect.sv
// Staircase detector: tracks runs of symbols 1,1..,2,2..,..,N and flags entry into step N.
// Optional saturating hit counter is built only when STAIR_DETECT_HITCNT_EN is defined.
module stair_detect #(
    parameter int W  = 2,
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [W-1:0]             num,
    output logic                     ans,
    output logic                     hit,
    output logic [$clog2(N+1)-1:0]   step,
    output logic [CW-1:0]            hit_cnt
);

    localparam int SW = $clog2(N+1);
    localparam logic [SW-1:0] TOP_S = SW'(N);
    localparam logic [SW-1:0] PRE_S = SW'(N - 1);
    localparam logic [W-1:0]  TOP_W = W'(N);
    localparam logic [W-1:0]  ONE_W = W'(1);

    // Handshake: num is consumed on a rising edge only while in_valid=1; there is
    // no back-pressure, the detector accepts a symbol every cycle. clr overrides in_valid.

    logic [SW-1:0] step_q;
    logic [SW-1:0] step_nxt;
    logic          hit_q;
    logic          hit_nxt;
    logic [W-1:0]  step_w;

    assign step_w = W'(step_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            step_q <= step_nxt;
            hit_q  <= hit_nxt;
        end
    end

    // Restart on 1 wins over dwell/advance; anything unmatched drops to idle.
    always_comb begin
        step_nxt = step_q;
        hit_nxt  = 1'b0;
        if (clr) begin
            step_nxt = '0;
        end else if (in_valid) begin
            if (num == ONE_W) begin
                step_nxt = SW'(1);
            end else if (step_q != '0 && num == step_w) begin
                step_nxt = step_q;
            end else if (step_q != '0 && step_q != TOP_S && num == W'(step_w + ONE_W)) begin
                step_nxt = step_q + SW'(1);
            end else begin
                step_nxt = '0;
            end
            hit_nxt = (step_q == PRE_S) && (num == TOP_W);
        end
    end

    assign step = step_q;
    assign ans  = (step_q == TOP_S);
    assign hit  = hit_q;

`ifdef STAIR_DETECT_HITCNT_EN
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (hit_nxt && cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_stair_detect.sv
// Bench for stair_detect (W=2, N=3, CW=2): random and directed symbol streams scored
// against an integer model of the staircase rules.
module tb_stair_detect;

    localparam int W  = 2;
    localparam int N  = 3;
    localparam int CW = 2;
    localparam int EW = 2 + 1 + 1 + CW;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic [W-1:0]  num;
    logic          ans;
    logic          hit;
    logic [1:0]    step;
    logic [CW-1:0] hit_cnt;

    stair_detect #(.W(W), .N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .num      (num),
        .ans      (ans),
        .hit      (hit),
        .step     (step),
        .hit_cnt  (hit_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int   m_k;
    int   m_cnt;
    logic m_hit;

    logic [EW-1:0] exp_q[$];
    int pass_cnt = 0;
    int total    = 0;

    function automatic logic [EW-1:0] model_pack();
        int c;
`ifdef STAIR_DETECT_HITCNT_EN
        c = m_cnt;
`else
        c = 0;
`endif
        return {2'(m_k), (m_k == N), m_hit, CW'(c)};
    endfunction

    function automatic void model_step(input logic c, input logic v, input int n);
        int prev;
        prev  = m_k;
        m_hit = 1'b0;
        if (c) begin
            m_k   = 0;
            m_cnt = 0;
        end else if (v) begin
            if (n == 1)                             m_k = 1;
            else if (m_k >= 1 && n == m_k)          m_k = m_k;
            else if (m_k >= 1 && m_k < N && n == m_k + 1) m_k = m_k + 1;
            else                                    m_k = 0;
            m_hit = (prev == N - 1) && (m_k == N);
            if (m_hit && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void model_reset();
        m_k   = 0;
        m_cnt = 0;
        m_hit = 1'b0;
    endfunction

    // driver tasks
    task automatic drive(input logic c, input logic v, input int n);
        @(negedge clk);
        clr      = c;
        in_valid = v;
        num      = W'(n);
        model_step(c, v, n);
        exp_q.push_back(model_pack());
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, int'(s[i]) - 48);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, int'($urandom_range(0, 3)));
    endtask

    task automatic check_direct(input string name, input logic [EW-1:0] exp_v);
        logic [EW-1:0] act;
        act = {step, ans, hit, hit_cnt};
        total++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got step=%0d ans=%0b hit=%0b hit_cnt=%0d, want step=%0d ans=%0b hit=%0b hit_cnt=%0d",
                      name, act[5:4], act[3], act[2], act[1:0], exp_v[5:4], exp_v[3], exp_v[2], exp_v[1:0]);
    endtask

    // scoreboard monitor: one expected entry per driven cycle
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_direct("cycle", e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; num = '0;
        model_reset();
        #2;
        check_direct("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;

        feed("123");            // basic climb, hit, count 1
        idle(2);
        feed("1122333");        // dwell, single hit
        feed("2");              // leave top
        feed("1203");           // 0 kills progress
        feed("13");             // no skipping
        drive(1'b1, 1'b0, 0);
        feed("123123123123");   // counter saturates
        drive(1'b1, 1'b1, 1);   // clr beats in_valid
        feed("12");
        idle(5);                // hold at step 2
        feed("3");
        feed("12");

        // async reset mid-clock at step 2
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_direct("async_reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        feed("3");              // must not reach top after reset
        feed("123");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) drive(1'b1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
            else if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, int'($urandom_range(0, 3)));
            else if ($urandom_range(0, 1) == 0) drive(1'b0, 1'b1, int'($urandom_range(0, 3)));
            else begin
                // bias toward climbing the staircase
                drive(1'b0, 1'b1, (m_k < N) ? m_k + 1 : int'($urandom_range(1, 3)));
            end
        end

        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
